vram_arbiter: RTL and testbench

Single-port video memory arbiter between the `vga512x256` scanout fetch, a host read/write port and a built-in screen-fill engine. It sits between those requesters and the 8K×16 synchronous video RAM, and issues at most one RAM access per clock. Priority is fixed: VGA, then host, then fill. Display fetch therefore has a constant latency regardless of host or fill traffic.

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_fill_seq.sv | 76 +++++++
 rtl/vram_arbiter.sv | 118 +++++++++++
 tb/tb_vram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and sizes for the video RAM arbiter and its fill sequencer.
package vram_pkg;

  localparam int VRAM_AW    = 13;
  localparam int VRAM_DW    = 16;
  localparam int VRAM_WORDS = 8192;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    VGA  = 2'd1,
    HOST = 2'd2,
    FILL = 2'd3
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/vram_fill_seq.sv
// Screen-fill engine: walks every RAM address once, writing a latched value
// whenever the arbiter hands it a slot.
module vram_fill_seq
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  input  logic          slot_grant,
  output logic          fill_req,
  output logic [AW-1:0] fill_addr,
  output logic [DW-1:0] fill_data,
  output logic          fill_busy,
  output logic          fill_done
);

  fill_state_t   state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;
  logic [DW-1:0] val_d, val_q;
  logic          done_d, done_q;
  logic          last;

  assign last = (cnt_q == {AW{1'b1}});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The done cycle still counts as busy, so a start there is dropped.
        if (fill_start && !done_q) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          val_d   = fill_value;
        end
      end
      ST_FILL: begin
        if (slot_grant) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  assign fill_req  = (state_q == ST_FILL);
  assign fill_addr = cnt_q;
  assign fill_data = val_q;
  assign fill_busy = (state_q == ST_FILL) || done_q;
  assign fill_done = done_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: fixed priority VGA > host > fill, one access
// per clock, with a decide / issue / return pipeline.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_valid,
  output logic [DW-1:0] vga_data,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  owner_t        owner_d, owner1_q, owner2_q;
  logic [AW-1:0] ram_addr_d, ram_addr_q;
  logic          ram_we_d, ram_we_q;
  logic [DW-1:0] ram_din_d, ram_din_q;
  logic          we2_q;
  logic          host_busy_d, host_busy_q;
  logic          fill_req, fill_grant;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;

  vram_fill_seq #(
    .AW(AW),
    .DW(DW)
  ) u_fill (
    .clk       (clk),
    .rst       (rst),
    .fill_start(fill_start),
    .fill_value(fill_value),
    .slot_grant(fill_grant),
    .fill_req  (fill_req),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .fill_busy (fill_busy),
    .fill_done (fill_done)
  );

  // Idle slots keep the last address/data so the RAM bus only toggles on use.
  always_comb begin
    owner_d    = NONE;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din_q;
    if (vga_req) begin
      owner_d    = VGA;
      ram_addr_d = vga_addr;
    end else if (host_req && !host_busy_q) begin
      owner_d    = HOST;
      ram_addr_d = host_addr;
      ram_we_d   = host_we;
      ram_din_d  = host_wdata;
    end else if (fill_req) begin
      owner_d    = FILL;
      ram_addr_d = fill_addr;
      ram_we_d   = 1'b1;
      ram_din_d  = fill_data;
    end
  end

  assign fill_grant = (owner_d == FILL);

  always_comb begin
    host_busy_d = host_busy_q;
    if (owner_d == HOST) begin
      host_busy_d = 1'b1;
    end else if (host_ack) begin
      host_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner1_q    <= NONE;
      owner2_q    <= NONE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      we2_q       <= 1'b0;
      host_busy_q <= 1'b0;
    end else begin
      owner1_q    <= owner_d;
      owner2_q    <= owner1_q;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      we2_q       <= ram_we_q;
      host_busy_q <= host_busy_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_din    = ram_din_q;
  assign vga_valid  = (owner2_q == VGA);
  assign vga_data   = vga_valid ? ram_dout : '0;
  assign host_ack   = (owner2_q == HOST);
  assign host_rdata = (host_ack && !we2_q) ? ram_dout : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 8Kx16 RAM and
// scoreboard queues for VGA fetches, host acks and fill writes.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [12:0] vga_addr;
  logic        vga_valid;
  logic [15:0] vga_data;
  logic        host_req;
  logic        host_we;
  logic [12:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        fill_start;
  logic [15:0] fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] mem [0:8191];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    int          cycle;
    logic [15:0] data;
  } vExp_t;

  typedef struct {
    int          cycle;
    logic        isRead;
    logic [15:0] data;
  } hExp_t;

  vExp_t       vgaQ[$];
  hExp_t       hostQ[$];

  bit          fillActive = 1'b0;
  int          fillAddrExp = 0;
  logic [15:0] fillValExp = '0;
  int          fillWrites = 0;
  int          fillDoneExp = 0;
  int          doneCount = 0;

  vram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_valid (vga_valid),
    .vga_data  (vga_data),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .fill_start(fill_start),
    .fill_value(fill_value),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM, read-before-write, data one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock step; single-cycle pulses are withdrawn automatically.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    vga_req    = 1'b0;
    fill_start = 1'b0;
  endtask

  task automatic waitCycle(input int t);
    while (cyc < t) applyStimulus();
  endtask

  task automatic vgaStart(input logic [12:0] a, input logic [15:0] d);
    vga_req  = 1'b1;
    vga_addr = a;
    vgaQ.push_back('{cyc + 2, d});
  endtask

  task automatic hostStart(input logic we, input logic [12:0] a, input logic [15:0] wd,
                           input logic [15:0] expRd, input int delay);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = wd;
    hostQ.push_back('{cyc + delay, !we, expRd});
  endtask

  task automatic hostWait();
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (host_ack) break;
    end
    if (!host_ack) checkOutput("host_ack_timeout", 64'(host_ack), 64'd1);
    host_req = 1'b0;
  endtask

  task automatic fillStart(input logic [15:0] val, input int stolen);
    fill_start  = 1'b1;
    fill_value  = val;
    fillValExp  = val;
    fillAddrExp = 0;
    fillWrites  = 0;
    fillDoneExp = cyc + 8193 + stolen;
    fillActive  = 1'b1;
  endtask

  task automatic waitFillDone();
    int d0;
    d0 = doneCount;
    for (int i = 0; i < 9000 && doneCount == d0; i++) applyStimulus();
    checkOutput("fill_done_seen", 64'(doneCount - d0), 64'd1);
    checkOutput("fill_busy_after_done", 64'(fill_busy), 64'd0);
  endtask

  // Scoreboard: pops expectations as the DUT produces results.
  always @(negedge clk) begin : monitor
    vExp_t v;
    hExp_t h;
    if (vga_valid) begin
      if (vgaQ.size() == 0) begin
        checkOutput("vga_spurious", 64'd1, 64'd0);
      end else begin
        v = vgaQ.pop_front();
        checkOutput("vga_cycle", 64'(cyc), 64'(v.cycle));
        checkOutput("vga_data", 64'(vga_data), 64'(v.data));
      end
    end
    if (host_ack) begin
      if (hostQ.size() == 0) begin
        checkOutput("host_spurious", 64'd1, 64'd0);
      end else begin
        h = hostQ.pop_front();
        checkOutput("host_ack_cycle", 64'(cyc), 64'(h.cycle));
        if (h.isRead) checkOutput("host_rdata", 64'(host_rdata), 64'(h.data));
      end
    end
    if (ram_we && fillActive) begin
      checkOutput("fill_addr", 64'(ram_addr), 64'(fillAddrExp));
      checkOutput("fill_data", 64'(ram_din), 64'(fillValExp));
      fillAddrExp++;
      fillWrites++;
    end
    if (fill_done) begin
      doneCount++;
      checkOutput("fill_done_cycle", 64'(cyc), 64'(fillDoneExp));
      checkOutput("fill_write_count", 64'(fillWrites), 64'd8192);
      fillActive = 1'b0;
    end
  end

  initial begin
    int s;
    int bad;
    int d0;
    rst        = 1'b1;
    vga_req    = 1'b0;
    vga_addr   = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    fill_start = 1'b0;
    fill_value = '0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'h8000 | 16'(i);
    mem[13'h0123] = 16'hBEEF;

    // Reset state
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_data", 64'({vga_data, host_rdata}), 64'd0);
    checkOutput("reset_ctrl", 64'({ram_din, ram_addr, ram_we, vga_valid, host_ack, fill_busy, fill_done}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // VGA fetch at cycle 10 returns at cycle 12
    waitCycle(10);
    vgaStart(13'h0123, 16'hBEEF);

    // Host write then read-back at the top address
    waitCycle(20);
    hostStart(1'b1, 13'h1FFF, 16'h5A5A, 16'h0000, 2);
    hostWait();
    applyStimulus();
    hostStart(1'b0, 13'h1FFF, 16'h0000, 16'h5A5A, 2);
    hostWait();

    // VGA and host in the same cycle: host acks one cycle late
    applyStimulus();
    vgaStart(13'h0123, 16'hBEEF);
    hostStart(1'b0, 13'h1FFF, 16'h0000, 16'h5A5A, 3);
    hostWait();
    applyStimulus();
    vgaStart(13'h1FFF, 16'h5A5A);
    repeat (4) applyStimulus();

    // Uncontended full fill with zero
    fillStart(16'h0000, 0);
    waitFillDone();
    bad = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== 16'h0000) bad++;
    checkOutput("fill_readback_nonzero", 64'(bad), 64'd0);
    vgaStart(13'h0123, 16'h0000);
    repeat (4) applyStimulus();

    // Fill under VGA and host traffic; each granted request steals one slot
    for (int j = 0; j < 4; j++) begin
      hostStart(1'b1, 13'h1F00 + 13'(j), 16'h1000 + 16'(j), 16'h0000, 2);
      hostWait();
      applyStimulus();
    end
    fillStart(16'hA5A5, 32);
    s = cyc;
    for (int k = 0; k < 16; k++) begin
      waitCycle(s + 20 + 16 * k);
      vgaStart(13'(k), 16'hA5A5);
      waitCycle(s + 28 + 16 * k);
      hostStart(1'b0, 13'h1F00 + 13'(k % 4), 16'h0000, 16'h1000 + 16'(k % 4), 2);
      hostWait();
    end
    waitFillDone();

    // Reset in the middle of a fill aborts it silently
    applyStimulus();
    fillStart(16'h7777, 0);
    for (int i = 0; i < 300 && fillWrites < 100; i++) applyStimulus();
    checkOutput("fill3_reached_100", 64'(fillWrites >= 100), 64'd1);
    fillActive = 1'b0;
    d0 = doneCount;
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_data", 64'({vga_data, host_rdata}), 64'd0);
    checkOutput("abort_ctrl", 64'({ram_din, ram_addr, ram_we, vga_valid, host_ack, fill_busy, fill_done}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("no_done_after_abort", 64'(doneCount - d0), 64'd0);
    checkOutput("busy_low_after_abort", 64'(fill_busy), 64'd0);

    // A fresh fill after the abort restarts at address 0
    fillStart(16'h3333, 0);
    waitFillDone();

    repeat (5) applyStimulus();
    checkOutput("vga_queue_drained", 64'(vgaQ.size()), 64'd0);
    checkOutput("host_queue_drained", 64'(hostQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
